// File: rtl/fork2_reg_if.sv
// Valid/ready bundle for fork2_reg: one input stream, two output branches (a, b).
interface fork2_reg_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic                  valid_out_a;
  logic                  ready_out_a;
  logic [DATA_WIDTH-1:0] data_out_b;
  logic                  valid_out_b;
  logic                  ready_out_b;

  // Environment side: produces the input stream, consumes both branches.
  modport master (
    output data_in, valid_in, ready_out_a, ready_out_b,
    input  ready_in, data_out_a, valid_out_a, data_out_b, valid_out_b
  );

  // Fork side.
  modport slave (
    input  data_in, valid_in, ready_out_a, ready_out_b,
    output ready_in, data_out_a, valid_out_a, data_out_b, valid_out_b
  );
endinterface

// File: rtl/fork2_reg.sv
// Registered two-way fork: each accepted input is delivered once on branch a and once on branch b.
// Define FORK2_REG_SKID_EN for a 2-entry FIFO per branch with a fully registered ready_in.
module fork2_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fork2_reg_if.slave  bus
);

  logic                  rdy [2];
  logic                  push;
  logic [DATA_WIDTH-1:0] head [2];

  always_comb begin
    rdy[0] = bus.ready_out_a;
    rdy[1] = bus.ready_out_b;
  end

  assign push            = bus.valid_in && bus.ready_in;
  assign bus.data_out_a  = head[0];
  assign bus.data_out_b  = head[1];

`ifdef FORK2_REG_SKID_EN
  logic [DATA_WIDTH-1:0] tail  [2];
  logic [1:0]            count [2];
  logic                  pop   [2];

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      pop[i] = (count[i] != 2'd0) && rdy[i];
    end
  end

  // Only registered counts feed ready_in, so no ready_out -> ready_in path exists.
  assign bus.ready_in    = (count[0] != 2'd2) && (count[1] != 2'd2);
  assign bus.valid_out_a = count[0] != 2'd0;
  assign bus.valid_out_b = count[1] != 2'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        case ({push, pop[i]})
          2'b11: begin
            // Count stays put; when full the tail advances so order is kept.
            if (count[i] == 2'd2) begin
              head[i] <= tail[i];
              tail[i] <= bus.data_in;
            end else begin
              head[i] <= bus.data_in;
            end
          end
          2'b10: begin
            if (count[i] == 2'd0) head[i] <= bus.data_in;
            else                  tail[i] <= bus.data_in;
            count[i] <= count[i] + 2'd1;
          end
          2'b01: begin
            head[i]  <= tail[i];
            count[i] <= count[i] - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end
`else
  logic valid_r [2];

  assign bus.ready_in    = (!valid_r[0] || rdy[0]) && (!valid_r[1] || rdy[1]);
  assign bus.valid_out_a = valid_r[0];
  assign bus.valid_out_b = valid_r[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        head[i]    <= '0;
        valid_r[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push) begin
          head[i]    <= bus.data_in;
          valid_r[i] <= 1'b1;
        end else if (rdy[i]) begin
          valid_r[i] <= 1'b0;
        end
      end
    end
  end
`endif

endmodule
